// File: rtl/poly_bram_reader.sv
// Streams one 64-word packed polynomial out of a coefficient BRAM as a ready/valid
// coefficient stream, with a credit-controlled 2-word buffer absorbing read latency.
module poly_bram_reader #(
    parameter int unsigned COEFF_W = 24,
    parameter int unsigned LANES   = 4,
    parameter int unsigned WORDS   = 64,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     swizzle,
    output logic                     busy,
    output logic                     done,
    output logic                     bram_en,
    output logic [ADDR_W-1:0]        bram_addr,
    input  logic [LANES*COEFF_W-1:0] bram_dout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [COEFF_W-1:0]       m_data,
    output logic                     m_last
);

    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned CNT_W  = $clog2(WORDS * LANES);
    localparam logic [CNT_W-1:0]  LastCoef = CNT_W'(WORDS * LANES - 1);
    localparam logic [ADDR_W:0]   LastWord = (ADDR_W + 1)'(WORDS - 1);
    localparam logic [LANE_W-1:0] LastLane = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                   state_q;
    logic [ADDR_W:0]          word_addr_q;
    logic [CNT_W-1:0]         coef_cnt_q;
    logic [LANE_W-1:0]        lane_q;
    logic                     swz_q;
    logic                     inflight_q;
    logic [1:0]               occ_q;
    logic [LANES*COEFF_W-1:0] buf0_q;
    logic [LANES*COEFF_W-1:0] buf1_q;

    logic                     hs;
    logic                     pop;
    logic                     push;
    logic [1:0]               credit;
    logic [LANE_W-1:0]        sel;

    // Words buffered plus the one read that may still be in flight.
    assign credit    = occ_q + {1'b0, inflight_q};
    assign bram_en   = (state_q == StRun) && (credit < 2'd2);
    assign bram_addr = word_addr_q[ADDR_W-1:0];
    assign m_valid   = (occ_q != 2'd0);
    assign hs        = m_valid & m_ready;
    assign pop       = hs && (lane_q == LastLane);
    assign push      = inflight_q;
    assign m_last    = m_valid && (coef_cnt_q == LastCoef);

    // Swizzled packing presents lanes 1,3,0,2 of each word.
    always_comb begin
        sel = lane_q;
        if (swz_q) begin
            case (lane_q)
                2'd0:    sel = 2'd1;
                2'd1:    sel = 2'd3;
                2'd2:    sel = 2'd0;
                default: sel = 2'd2;
            endcase
        end
    end

    always_comb begin
        m_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (sel == LANE_W'(k)) begin
                m_data = buf0_q[k*COEFF_W +: COEFF_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q     <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            inflight_q <= bram_en;
            if (hs) begin
                lane_q <= lane_q + 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        buf0_q <= bram_dout;
                    end else begin
                        buf1_q <= bram_dout;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= bram_dout;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= bram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            word_addr_q <= '0;
            coef_cnt_q  <= '0;
            swz_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (hs && (coef_cnt_q != LastCoef)) begin
                coef_cnt_q <= coef_cnt_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    // A start coinciding with done is still the tail of the last run.
                    if (start && !done) begin
                        swz_q       <= swizzle;
                        word_addr_q <= '0;
                        coef_cnt_q  <= '0;
                        busy        <= 1'b1;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (bram_en) begin
                        word_addr_q <= word_addr_q + 1'b1;
                        if (word_addr_q == LastWord) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (hs && (coef_cnt_q == LastCoef)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
